// File: rtl/cnt_event_mon.sv
// -----------------------------------------------------------------------------
// cnt_event_mon
// Watches a free-running counter value and logs every change as an event word
// {wrap, value} into a small FIFO. The FIFO drains through a valid/ready
// interface so a slow consumer can read the counter history in order.
// Overflow (an event dropped because the FIFO was full) sets a sticky flag.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset (release synchronous to clk)
//   cnt        in   monitored counter value [CNT_W-1:0]
//   mon_en     in   monitor enable; 0 disarms capture
//   out_valid  out  FIFO non-empty, head entry on out_data
//   out_ready  in   consumer accepts head when out_valid=1
//   out_data   out  {wrap, value} [CNT_W:0]; zero when FIFO is empty
//   level      out  FIFO occupancy 0..DEPTH [ADDR_W:0]
//   ovf        out  sticky overflow flag
//   clr_ovf    in   synchronous clear of ovf (a same-cycle drop wins)
//   thr_hit    out  (CNT_EVENT_MON_THRESH_EN only) one-cycle pulse after an
//                   event whose value equals THRESH, pushed or dropped
//
// Build option: define CNT_EVENT_MON_THRESH_EN to add the THRESH parameter and
// the thr_hit output.
// -----------------------------------------------------------------------------
module cnt_event_mon #(
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
`ifdef CNT_EVENT_MON_THRESH_EN
    ,
    parameter logic [CNT_W-1:0] THRESH = 8'hFF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              mon_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W:0]    out_data,
    output logic [ADDR_W:0]   level,
    output logic              ovf,
    input  logic              clr_ovf
`ifdef CNT_EVENT_MON_THRESH_EN
    ,
    output logic              thr_hit
`endif
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    // Event storage; intentionally not reset, occupancy is tracked by r_level.
    logic [CNT_W:0]    r_mem [DEPTH];

    logic [CNT_W-1:0]  r_prev;
    logic              r_prev_vld;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_level;
    logic              r_ovf;

    logic              w_event;
    logic              w_wrap;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // An event needs an armed reference value; unsigned decrease marks a wrap
    // (rollover or upstream reset).
    assign w_event = mon_en && r_prev_vld && (cnt != r_prev);
    assign w_wrap  = (cnt < r_prev);
    assign w_full  = (r_level == LP_DEPTH);
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && out_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    // Reference value tracking: arming and event edges both load cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (!mon_en) begin
            r_prev_vld <= 1'b0;
        end else begin
            r_prev_vld <= 1'b1;
            r_prev     <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_wrap, cnt};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rptr];
    assign level     = r_level;
    assign ovf       = r_ovf;

`ifdef CNT_EVENT_MON_THRESH_EN
    logic r_thr_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_thr_hit <= 1'b0;
        end else begin
            r_thr_hit <= w_event && (cnt == THRESH);
        end
    end

    assign thr_hit = r_thr_hit;
`endif

endmodule
